// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and constants for the data-memory responder
package mips_mem_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mips_sram_core.sv
// rtl/mips_sram_core.sv - single-port word RAM with one-cycle registered read
module mips_sram_core
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write on we; read is registered every cycle and returns pre-write contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - CPU data-bus memory target with wait states and tri-state read return
// Optional feature macro: MIPS_DMEM_RANGE_CHECK_EN (flag DAddr >= DEPTH via DErr instead of wrapping)
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] DAddr,
  inout  tri   [WORD_W-1:0] Data,
  input  logic              DRead,
  input  logic              DWrite,
  output logic              DReady,
  output logic              DErr
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("mips_dmem_responder: WAIT_CYCLES must be 0..15");
  end
  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("mips_dmem_responder: DEPTH must equal 2**AW");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, next_state;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, enter_resp;
  op_t               op_q, req_op, cur_op;
  logic              err_q, req_oor, cur_oor;
  logic [AW-1:0]     addr_q, cur_addr;
  logic [WORD_W-1:0] wdata_q, cur_wdata, rdata, rsp_data;
  logic              we, drive;

`ifdef MIPS_DMEM_RANGE_CHECK_EN
  assign req_oor = (DAddr >= WORD_W'(DEPTH));
  assign DErr    = (state_q == ST_RESP) && err_q;
`else
  logic unused_upper;
  assign unused_upper = ^DAddr[WORD_W-1:AW];
  assign req_oor      = 1'b0;
  assign DErr         = 1'b0;
`endif

  // Next state, wait counter and acceptance; RESP accepts like IDLE for back-to-back traffic
  always_comb begin
    next_state = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (DRead || DWrite) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = ST_WAIT;
            cnt_d      = CNT_LOAD;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          next_state = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // With zero wait states RAM access happens on the accepting edge, so use live bus values then
  assign req_op    = DWrite ? OP_WRITE : OP_READ;
  assign cur_op    = accept ? req_op : op_q;
  assign cur_oor   = accept ? req_oor : err_q;
  assign cur_addr  = accept ? DAddr[AW-1:0] : addr_q;
  assign cur_wdata = accept ? Data : wdata_q;
  assign we        = enter_resp && !Reset && (cur_op == OP_WRITE) && !cur_oor;

  // State register and request latch; reset drops any request in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= next_state;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= req_op;
        err_q   <= req_oor;
        addr_q  <= DAddr[AW-1:0];
        wdata_q <= Data;
      end
    end
  end

  mips_sram_core #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (Clk),
    .we    (we),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (rdata)
  );

  assign DReady   = (state_q == ST_RESP);
  assign drive    = (state_q == ST_RESP) && (op_q == OP_READ);
  assign rsp_data = err_q ? '0 : rdata;
  assign Data     = drive ? rsp_data : 'z;

endmodule
